// File: rtl/rx_bringup_seq.sv
// Receiver front-end bring-up sequencer: ordered register-bank writes, settle wait, capture window.
// Define BRINGUP_PI_OFFSET_EN to append the four PI control offset writes (addresses 4..7).
module rx_bringup_seq #(
  parameter int PI_W          = 9,
  parameter int SETTLE_CYCLES = 64,
  parameter int RECORD_CYCLES = 160,
  parameter int ACK_TIMEOUT   = 255,
  parameter int PI_OFFSET_0   = 0,
  parameter int PI_OFFSET_1   = 149,
  parameter int PI_OFFSET_2   = 298,
  parameter int PI_OFFSET_3   = 447
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic            abort,
  output logic            wr_req,
  output logic [2:0]      wr_addr,
  output logic [PI_W-1:0] wr_data,
  input  logic            wr_ack,
  output logic            record_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_WR     | wr_req high for current list entry, waiting for ack
  // S_GAP    | one idle cycle between writes
  // S_SETTLE | settle countdown after the last write
  // S_RECORD | capture window open
  // S_DONE   | sequence complete, holds until start/abort
  // S_ERROR  | ack timeout, holds until start/abort
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_SETTLE,
    S_RECORD,
    S_DONE,
    S_ERROR
  } state_t;

`ifdef BRINGUP_PI_OFFSET_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd2;
`endif

  localparam logic [15:0] TO_MAX    = 16'(ACK_TIMEOUT);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] RECORD_LD = 16'(RECORD_CYCLES - 1);

  // Index 3 is skipped in the address space: PI offsets live at 4..7.
  function automatic logic [2:0] entry_addr(input logic [2:0] idx);
    entry_addr = (idx < 3'd3) ? idx : idx + 3'd1;
  endfunction

  function automatic logic [PI_W-1:0] entry_data(input logic [2:0] idx);
    case (idx)
      3'd3:    entry_data = PI_W'(PI_OFFSET_0);
      3'd4:    entry_data = PI_W'(PI_OFFSET_1);
      3'd5:    entry_data = PI_W'(PI_OFFSET_2);
      3'd6:    entry_data = PI_W'(PI_OFFSET_3);
      default: entry_data = PI_W'(1);
    endcase
  endfunction

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [15:0]     r_cnt;
  logic            r_wr_req;
  logic [2:0]      r_wr_addr;
  logic [PI_W-1:0] r_wr_data;
  logic            r_record_en;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  state_t          w_state_nxt;
  logic [2:0]      w_idx_nxt;
  logic [15:0]     w_cnt_nxt;
  logic            w_wr_req_nxt;
  logic [2:0]      w_wr_addr_nxt;
  logic [PI_W-1:0] w_wr_data_nxt;
  logic            w_record_en_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            w_state_nxt = S_WR;
            w_idx_nxt   = 3'd0;
            w_cnt_nxt   = 16'd0;
          end
        end
        S_WR: begin
          if (wr_ack) begin
            w_state_nxt = S_GAP;
          end else if (r_cnt == TO_MAX) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = SETTLE_LD;
          end else begin
            w_state_nxt = S_WR;
            w_idx_nxt   = r_idx + 3'd1;
            w_cnt_nxt   = 16'd0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 16'd0) begin
            w_state_nxt = S_RECORD;
            w_cnt_nxt   = RECORD_LD;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
        S_RECORD: begin
          if (r_cnt == 16'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so the bank sees glitch-free levels.
    w_wr_req_nxt    = (w_state_nxt == S_WR);
    w_wr_addr_nxt   = w_wr_req_nxt ? entry_addr(w_idx_nxt) : 3'd0;
    w_wr_data_nxt   = w_wr_req_nxt ? entry_data(w_idx_nxt) : '0;
    w_record_en_nxt = (w_state_nxt == S_RECORD);
    w_busy_nxt      = (w_state_nxt == S_WR) || (w_state_nxt == S_GAP) ||
                      (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RECORD);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_err_nxt       = (w_state_nxt == S_ERROR);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 16'd0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= 3'd0;
      r_wr_data   <= '0;
      r_record_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr_req    <= w_wr_req_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_record_en <= w_record_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign wr_req    = r_wr_req;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign record_en = r_record_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
